// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and data
// accesses: grant cycle then response cycle, data-first with alternation.
module mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic [31:0]      if_rdata,
  output logic             if_ready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [3:0]       d_be,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic [31:0]      d_rdata,
  output logic             d_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a requester raises *_req with stable address/data and holds it
  // until its *_ready pulses for exactly one cycle; the grant happens in the
  // cycle before that pulse and read data is valid only during the pulse.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_d;
  logic              grant_if;

  // Data wins a tie unless it won the previous one.
  assign grant_d  = d_req && !(if_req && (last_grant_q == GNT_D));
  assign grant_if = if_req && !grant_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'b0000;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    if_ready     = 1'b0;
    if_rdata     = 32'h0;
    d_ready      = 1'b0;
    d_rdata      = 32'h0;

    if (reset) begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            mem_en       = 1'b1;
            mem_we       = d_we;
            mem_be       = d_we ? d_be : 4'b1111;
            mem_addr     = d_addr;
            mem_wdata    = d_wdata;
            state_d      = D_WAIT;
            last_grant_d = GNT_D;
          end else if (grant_if) begin
            mem_en       = 1'b1;
            mem_be       = 4'b1111;
            mem_addr     = if_addr;
            state_d      = IF_WAIT;
            last_grant_d = GNT_IF;
          end
        end
        IF_WAIT: begin
          if_ready = 1'b1;
          if_rdata = mem_rdata;
          state_d  = IDLE;
        end
        D_WAIT: begin
          d_ready = 1'b1;
          d_rdata = mem_rdata;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Whenever both sides request, one of them is necessarily stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (if_req && d_req && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IF;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to single-port memory arbiter that sequences the core's instruction-fetch and data accesses onto one shared synchronous-read memory. It sits between the ARM core (fetch port driven from PC/Instr; data port driven from ALUResult/WriteData/ReadData/MemWrite/be) and a unified 32-bit RAM. Each access takes a grant cycle followed by a response cycle, and conflicts are resolved by data-first priority with alternation. It also keeps a saturating count of conflict cycles for performance analysis.

## Interface
- CNT_W, 16, width of the conflict counter
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch byte address, stable while if_req
- if_rdata  out  32  fetch data, valid only while if_ready=1
- if_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid only while d_ready=1
- d_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

## Operation
- State machine states: IDLE, IF_WAIT, D_WAIT. A 1-bit last_grant register holds IF or D.
- IDLE, grant decision made combinationally from the current-cycle requests:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both requested: grant D unless last_grant==D, in which case grant IF.
  - Neither requested: mem_en=0 and state stays IDLE.
- Grant D drives memory outputs in the same cycle: mem_en=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata. mem_be=d_be if d_we, else 4'b1111. Next state D_WAIT; last_grant<=D.
- Grant IF drives memory outputs in the same cycle: mem_en=1, mem_we=0, mem_be=4'b1111, mem_addr=if_addr, mem_wdata=0. Next state IF_WAIT; last_grant<=IF.
- IF_WAIT: if_ready=1, if_rdata=mem_rdata, mem_en=0. Next state IDLE.
- D_WAIT: d_ready=1, mem_en=0. d_rdata=mem_rdata for loads; for stores d_rdata is a don't-care. Next state IDLE.
- No access is issued in a WAIT cycle. A requester that sees ready may drop its request or present a new one. The new request is arbitrated in the following IDLE cycle.
- When not granted or waiting, if_rdata and d_rdata are 0, and ready outputs are 0.
- conflict_cnt increments by 1 in any cycle where one requester is denied in IDLE or is waiting behind the other's WAIT. In practice this is any cycle with if_req && d_req && state != the requester's own WAIT. It saturates at 2^CNT_W−1 and never wraps.
- Requests dropped before ready while not granted are simply forgotten. Dropping after grant is illegal; the access still completes and ready still pulses.

## Timing
- Latency from request to ready is 1 cycle (grant in cycle N, ready in N+1) when uncontended.
- Sustained throughput is one access per 2 cycles.
- With both requesters continuously active, grants alternate D, IF, D, IF, …
- Each requester waits at most 2 extra cycles behind the other.
- The write is committed by the memory at the rising edge that ends the grant cycle.
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, last_grant=IF, conflict_cnt=0;
  - mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0;
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
  - All memory outputs are also forced to 0 combinationally while reset=0.
- Reset asserted mid-access (in a WAIT state) aborts the response: ready never pulses. A store already committed stays committed.
- Release of reset behaves as IDLE with last_grant=IF. A first simultaneous request therefore grants D.

## Test plan
- Reset check: hold reset=0 with random inputs → all outputs 0, conflict_cnt=0. Release, then if_req=1, if_addr=0x100 → mem_en=1, mem_addr=0x100 that cycle; next cycle if_ready=1, if_rdata=mem_rdata.
- Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x2004, d_wdata=0xDEADBEEF → mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; d_ready=1 next cycle.
- Load: d_req=1, d_we=0, d_addr=0x2004 → mem_be=1111; memory returns 0x0000BEEF → d_rdata=0x0000BEEF on the d_ready cycle.
- Contention: if_req and d_req both held for 8 cycles → grants D, IF, D, IF; each ready pulses twice; conflict_cnt increments by the number of cycles in which a request was waiting.
- Saturation: CNT_W=4, contention held for 40 cycles → conflict_cnt stops at 15.
- Reset mid-access: assert reset in D_WAIT → d_ready stays 0 and state returns to IDLE. After release, with both requests asserted, D is granted first.
